// File: rtl/ghash_accum.sv
// Iterative GHASH accumulator: Y_i = (Y_{i-1} ^ X_i) * H over GF(2^128), using a
// digit-serial shift-and-add multiplier that consumes DIGIT operand bits per clock.
module ghash_accum #(
    parameter int DIGIT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] h_in,
    input  logic         h_load,
    input  logic [127:0] blk_in,
    input  logic         blk_valid,
    input  logic         blk_last,
    output logic         blk_ready,
    output logic [127:0] tag_out,
    output logic         tag_valid,
    input  logic         tag_ready,
    output logic         busy
);
    localparam int N  = 128 / DIGIT;
    localparam int CW = $clog2(N);
    localparam logic [127:0] R_POLY = 128'hE1000000000000000000000000000000;

    typedef enum logic [1:0] {IDLE, MUL, OUT} state_t;

    state_t         state_reg;
    logic [127:0]   h_reg;
    logic [127:0]   y_reg;
    logic [127:0]   a_reg;
    logic [127:0]   v_reg;
    logic [127:0]   z_reg;
    logic [127:0]   tag_reg;
    logic [CW-1:0]  cnt_reg;
    logic           last_q;
    logic           tag_valid_reg;
    logic           busy_reg;
    logic [127:0]   z_next;
    logic [127:0]   v_next;

    // One digit step: bit 127 of A is the x^0 coefficient, so A is consumed MSB-first
    // while V is repeatedly multiplied by x (right shift in GCM bit order).
    always_comb begin
        z_next = z_reg;
        v_next = v_reg;
        for (int i = 0; i < DIGIT; i++) begin
            if (a_reg[127-i]) begin
                z_next = z_next ^ v_next;
            end
            v_next = v_next[0] ? ((v_next >> 1) ^ R_POLY) : (v_next >> 1);
        end
    end

    assign blk_ready = (state_reg == IDLE) && !h_load;
    assign tag_out   = tag_reg;
    assign tag_valid = tag_valid_reg;
    assign busy      = busy_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            h_reg         <= '0;
            y_reg         <= '0;
            a_reg         <= '0;
            v_reg         <= '0;
            z_reg         <= '0;
            tag_reg       <= '0;
            cnt_reg       <= '0;
            last_q        <= 1'b0;
            tag_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (h_load) begin
                        h_reg <= h_in;
                        y_reg <= '0;
                    end else if (blk_valid) begin
                        a_reg     <= y_reg ^ blk_in;
                        v_reg     <= h_reg;
                        z_reg     <= '0;
                        cnt_reg   <= '0;
                        last_q    <= blk_last;
                        busy_reg  <= 1'b1;
                        state_reg <= MUL;
                    end
                end
                MUL: begin
                    a_reg   <= a_reg << DIGIT;
                    z_reg   <= z_next;
                    v_reg   <= v_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CW'(N - 1)) begin
                        y_reg    <= z_next;
                        busy_reg <= 1'b0;
                        if (last_q) begin
                            tag_reg       <= z_next;
                            tag_valid_reg <= 1'b1;
                            state_reg     <= OUT;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                OUT: begin
                    // H survives the handshake so back-to-back messages need no reload.
                    if (tag_ready) begin
                        tag_valid_reg <= 1'b0;
                        y_reg         <= '0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ghash_accum.sv
// Bench for ghash_accum: two instances (DIGIT=1 and DIGIT=8) exercised in turn against
// a transaction-level model built on a polynomial-domain GF(2^128) multiply.
module tb_ghash_accum;
    localparam int ST_IDLE = 0;
    localparam int ST_MUL  = 1;
    localparam int ST_OUT  = 2;

    localparam logic [127:0] H_ID = 128'h80000000000000000000000000000000;
    localparam logic [127:0] H_K  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] X_C  = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] X_L  = 128'h00000000000000000000000000000080;
    localparam logic [127:0] Y_1  = 128'h5e2ec746917062882c85b0685353deb7;
    localparam logic [127:0] T_K  = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_s       [2];
    logic [127:0] h_in_s      [2];
    logic         h_load_s    [2];
    logic [127:0] blk_in_s    [2];
    logic         blk_valid_s [2];
    logic         blk_last_s  [2];
    logic         blk_ready_s [2];
    logic [127:0] tag_out_s   [2];
    logic         tag_valid_s [2];
    logic         tag_ready_s [2];
    logic         busy_s      [2];
    logic [127:0] y_dbg       [2];
    logic [127:0] h_dbg       [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            ghash_accum #(.DIGIT(gi == 0 ? 1 : 8)) u_dut (
                .clk       (clk),
                .rst       (rst_s[gi]),
                .h_in      (h_in_s[gi]),
                .h_load    (h_load_s[gi]),
                .blk_in    (blk_in_s[gi]),
                .blk_valid (blk_valid_s[gi]),
                .blk_last  (blk_last_s[gi]),
                .blk_ready (blk_ready_s[gi]),
                .tag_out   (tag_out_s[gi]),
                .tag_valid (tag_valid_s[gi]),
                .tag_ready (tag_ready_s[gi]),
                .busy      (busy_s[gi])
            );
            assign y_dbg[gi] = u_dut.y_reg;
            assign h_dbg[gi] = u_dut.h_reg;
        end
    endgenerate

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Multiply as ordinary polynomials (bit-reversed into x^k = bit k), then reduce.
    function automatic logic [127:0] gf_mult(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] ra, r;
        logic [255:0] rb, p, red;
        ra = '0; rb = '0; p = '0; r = '0;
        red = (256'd1 << 128) | 256'h87;
        for (int i = 0; i < 128; i++) begin
            ra[i] = a[127-i];
            rb[i] = b[127-i];
        end
        for (int i = 0; i < 128; i++)
            if (ra[i]) p = p ^ (rb << i);
        for (int k = 254; k >= 128; k--)
            if (p[k]) p = p ^ (red << (k - 128));
        for (int i = 0; i < 128; i++) r[127-i] = p[i];
        return r;
    endfunction

    // Transaction-level model, one per instance.
    int           m_st   [2];
    int           m_cnt  [2];
    logic [127:0] m_h    [2];
    logic [127:0] m_y    [2];
    logic [127:0] m_res  [2];
    logic [127:0] m_tag  [2];
    logic         m_last [2];
    logic         m_tagv [2];
    bit           cmp_en = 0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_s[i]) begin
                m_st[i] <= ST_IDLE; m_h[i] <= '0; m_y[i] <= '0;
                m_tag[i] <= '0; m_tagv[i] <= 1'b0; m_cnt[i] <= 0;
            end else if (m_st[i] == ST_IDLE) begin
                if (h_load_s[i]) begin
                    m_h[i] <= h_in_s[i];
                    m_y[i] <= '0;
                end else if (blk_valid_s[i]) begin
                    m_res[i]  <= gf_mult(m_y[i] ^ blk_in_s[i], m_h[i]);
                    m_cnt[i]  <= (i == 0) ? 128 : 16;
                    m_last[i] <= blk_last_s[i];
                    m_st[i]   <= ST_MUL;
                end
            end else if (m_st[i] == ST_MUL) begin
                if (m_cnt[i] == 1) begin
                    m_y[i] <= m_res[i];
                    if (m_last[i]) begin
                        m_tag[i]  <= m_res[i];
                        m_tagv[i] <= 1'b1;
                        m_st[i]   <= ST_OUT;
                    end else begin
                        m_st[i] <= ST_IDLE;
                    end
                end else begin
                    m_cnt[i] <= m_cnt[i] - 1;
                end
            end else begin
                if (tag_ready_s[i]) begin
                    m_tagv[i] <= 1'b0;
                    m_y[i]    <= '0;
                    m_st[i]   <= ST_IDLE;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                check128($sformatf("i%0d blk_ready", i), 128'(blk_ready_s[i]),
                         128'(m_st[i] == ST_IDLE && !h_load_s[i]));
                check128($sformatf("i%0d busy", i), 128'(busy_s[i]), 128'(m_st[i] == ST_MUL));
                check128($sformatf("i%0d tag_valid", i), 128'(tag_valid_s[i]), 128'(m_tagv[i]));
                check128($sformatf("i%0d tag_out", i), tag_out_s[i], m_tag[i]);
                check128($sformatf("i%0d Y", i), y_dbg[i], m_y[i]);
                check128($sformatf("i%0d H", i), h_dbg[i], m_h[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_h(input int u, input logic [127:0] h);
        h_in_s[u] = h;
        h_load_s[u] = 1'b1;
        tick();
        h_load_s[u] = 1'b0;
    endtask

    task automatic accept_tag(input int u);
        tag_ready_s[u] = 1'b1;
        tick();
        tag_ready_s[u] = 1'b0;
        check128("tag_valid after accept", 128'(tag_valid_s[u]), 128'(0));
    endtask

    // Offer a block, wait for its accept, then count edges until the multiply completes.
    task automatic send_block(input int u, input logic [127:0] blk, input logic last, input bit pulse);
        bit ok, accepted, done;
        int n;
        accepted = 0; done = 0; n = 0;
        blk_in_s[u] = blk; blk_last_s[u] = last; blk_valid_s[u] = 1'b1;
        for (int k = 0; k < 200 && !accepted; k++) begin
            @(negedge clk);
            ok = blk_ready_s[u];
            tick();
            if (ok) accepted = 1;
        end
        blk_valid_s[u] = 1'b0;
        blk_in_s[u] = ~blk;
        check128("block accepted", 128'(accepted), 128'(1));
        for (int k = 0; k < 300 && !done; k++) begin
            @(posedge clk);
            n++;
            #1;
            if (pulse) begin
                h_load_s[u] = (n == 3);
                h_in_s[u] = 128'hdeadbeef;
            end
            if (!busy_s[u]) done = 1;
        end
        h_load_s[u] = 1'b0;
        check128("latency", 128'(n), 128'((u == 0) ? 128 : 16));
        check128("tag_valid vs last", 128'(tag_valid_s[u]), 128'(last));
    endtask

    task automatic run_case2(input int u);
        send_block(u, X_C, 1'b0, 0);
        check128("intermediate Y", y_dbg[u], Y_1);
        send_block(u, X_L, 1'b1, 0);
        check128("case2 tag", tag_out_s[u], T_K);
    endtask

    task automatic run_tests(input int u);
        int cyc;
        rst_s[u] = 1'b1;
        tick(); tick();
        rst_s[u] = 1'b0;
        check128("reset blk_ready", 128'(blk_ready_s[u]), 128'(1));
        check128("reset tag_valid", 128'(tag_valid_s[u]), 128'(0));
        check128("reset busy", 128'(busy_s[u]), 128'(0));
        check128("reset tag_out", tag_out_s[u], 128'(0));
        check128("reset H", h_dbg[u], 128'(0));

        // Identity key
        load_h(u, H_ID);
        send_block(u, X_C, 1'b1, 0);
        check128("identity tag", tag_out_s[u], X_C);
        accept_tag(u);

        // GCM case 2 and backpressure
        load_h(u, H_K);
        run_case2(u);
        for (int k = 0; k < 20; k++) begin
            tick();
            check128("bp tag_valid", 128'(tag_valid_s[u]), 128'(1));
            check128("bp tag_out", tag_out_s[u], T_K);
            check128("bp blk_ready", 128'(blk_ready_s[u]), 128'(0));
        end
        accept_tag(u);
        check128("Y cleared", y_dbg[u], 128'(0));
        check128("tag_out held", tag_out_s[u], T_K);
        check128("idle blk_ready", 128'(blk_ready_s[u]), 128'(1));
        run_case2(u);
        accept_tag(u);

        // h_load wins over a concurrent block
        load_h(u, 128'(0));
        h_in_s[u] = H_K; h_load_s[u] = 1'b1;
        blk_in_s[u] = X_C; blk_last_s[u] = 1'b0; blk_valid_s[u] = 1'b1;
        @(negedge clk);
        check128("prio blk_ready", 128'(blk_ready_s[u]), 128'(0));
        tick();
        h_load_s[u] = 1'b0; blk_valid_s[u] = 1'b0;
        check128("prio H", h_dbg[u], H_K);
        check128("prio not consumed", 128'(busy_s[u]), 128'(0));
        run_case2(u);
        accept_tag(u);

        // Reset in the middle of a multiply
        load_h(u, H_K);
        blk_in_s[u] = X_C; blk_last_s[u] = 1'b0; blk_valid_s[u] = 1'b1;
        tick();
        blk_valid_s[u] = 1'b0;
        check128("mid busy", 128'(busy_s[u]), 128'(1));
        cyc = (u == 0) ? 40 : 8;
        repeat (cyc) tick();
        rst_s[u] = 1'b1;
        tick();
        rst_s[u] = 1'b0;
        check128("abort busy", 128'(busy_s[u]), 128'(0));
        check128("abort tag_valid", 128'(tag_valid_s[u]), 128'(0));
        check128("abort H", h_dbg[u], 128'(0));
        check128("abort blk_ready", 128'(blk_ready_s[u]), 128'(1));
        load_h(u, H_K);
        run_case2(u);
        accept_tag(u);

        // Zero key, then h_load pulse during MUL
        load_h(u, 128'(0));
        send_block(u, X_C, 1'b0, 0);
        send_block(u, X_L, 1'b1, 0);
        check128("zero key tag", tag_out_s[u], 128'(0));
        accept_tag(u);
        load_h(u, H_K);
        send_block(u, X_C, 1'b0, 1);
        check128("H after pulse", h_dbg[u], H_K);
        send_block(u, X_L, 1'b1, 0);
        check128("pulse case2 tag", tag_out_s[u], T_K);
        accept_tag(u);

        rst_s[u] = 1'b1;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_s[i] = 1'b1; h_in_s[i] = '0; h_load_s[i] = 1'b0;
            blk_in_s[i] = '0; blk_valid_s[i] = 1'b0; blk_last_s[i] = 1'b0;
            tag_ready_s[i] = 1'b0;
            m_st[i] = ST_IDLE; m_cnt[i] = 0; m_h[i] = '0; m_y[i] = '0;
            m_res[i] = '0; m_tag[i] = '0; m_last[i] = 1'b0; m_tagv[i] = 1'b0;
        end
        check128("model identity", gf_mult(X_C, H_ID), X_C);
        check128("model Y1", gf_mult(X_C, H_K), Y_1);
        check128("model tag", gf_mult(Y_1 ^ X_L, H_K), T_K);
        check128("model zero", gf_mult(X_C, 128'(0)), 128'(0));
        tick();
        cmp_en = 1;
        for (int u = 0; u < 2; u++) run_tests(u);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
